// File: rtl/ttt_pkg.sv
// ttt_pkg: shared constants for the tic-tac-toe game sequencer
//   state_e   : controller states
//   WIN_LINES : cell indices of the 3 rows, 3 columns and 2 diagonals
//   W_*       : winner encodings; NUM_CELLS : grid size
package ttt_pkg;
  localparam int NUM_CELLS = 9;
  typedef enum logic [2:0] {S_CLEAR, S_WAIT, S_COMMIT, S_CHECK, S_DONE} state_e;
  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_P0   = 2'b01;
  localparam logic [1:0] W_P1   = 2'b10;
  localparam logic [1:0] W_DRAW = 2'b11;
  localparam logic [3:0] WIN_LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };
endpackage

// File: rtl/ttt_line_check.sv
// ttt_line_check: combinational win/full evaluation of the 3x3 grid
//   cell_valid/cell_symbol : per-cell occupancy and stored symbol
//   win/win_sym            : some line is complete, and with which symbol
//   full                   : all cells occupied
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [NUM_CELLS-1:0] cell_valid,
  input  logic [NUM_CELLS-1:0] cell_symbol,
  output logic                 win,
  output logic                 win_sym,
  output logic                 full
);
  assign full = &cell_valid;
  always_comb begin
    win = 1'b0;
    win_sym = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if (cell_valid[WIN_LINES[l][0]] && cell_valid[WIN_LINES[l][1]] && cell_valid[WIN_LINES[l][2]] &&
          cell_symbol[WIN_LINES[l][0]] == cell_symbol[WIN_LINES[l][1]] &&
          cell_symbol[WIN_LINES[l][1]] == cell_symbol[WIN_LINES[l][2]]) begin
        win = 1'b1;
        win_sym = cell_symbol[WIN_LINES[l][0]];
      end
    end
  end
endmodule

// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: tic-tac-toe sequencer driving a 9-cell storage array
//   reset/new_game        : sync restart (reset has priority)
//   pX_req/pX_pos         : move requests, only the on-turn player is sampled
//   cell_valid/symbol     : grid contents read back from the cells
//   cell_reset/cell_set/set_symbol : cell write controls
//   turn, move_ack/err, game_over, winner : game status
module ttt_game_ctrl
  import ttt_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_game,
  input  logic                 p0_req,
  input  logic [3:0]           p0_pos,
  input  logic                 p1_req,
  input  logic [3:0]           p1_pos,
  input  logic [NUM_CELLS-1:0] cell_valid,
  input  logic [NUM_CELLS-1:0] cell_symbol,
  output logic                 cell_reset,
  output logic [NUM_CELLS-1:0] cell_set,
  output logic                 set_symbol,
  output logic                 turn,
  output logic                 move_ack,
  output logic                 move_err,
  output logic                 game_over,
  output logic [1:0]           winner
);
  state_e      state_q;
  logic [3:0]  pos_q;
  logic        turn_q;
  logic [1:0]  winner_q;
  logic        ack_q;
  logic        err_q;
  logic        win;
  logic        win_sym;
  logic        full;
  logic        req;
  logic [3:0]  pos;
  logic [15:0] occ;
  ttt_line_check u_line_check (
    .cell_valid (cell_valid),
    .cell_symbol(cell_symbol),
    .win        (win),
    .win_sym    (win_sym),
    .full       (full)
  );
  assign req = turn_q ? p1_req : p0_req;
  assign pos = turn_q ? p1_pos : p0_pos;
  // widened so out-of-range positions index a guaranteed-zero bit
  assign occ = {{(16 - NUM_CELLS){1'b0}}, cell_valid};
  always_ff @(posedge clk) begin
    ack_q <= 1'b0;
    err_q <= 1'b0;
    if (reset || new_game) begin
      state_q  <= S_CLEAR;
      turn_q   <= 1'b0;
      winner_q <= W_NONE;
    end else begin
      case (state_q)
        S_CLEAR:  state_q <= S_WAIT;
        S_WAIT: if (req) begin
          if (pos >= 4'(NUM_CELLS) || occ[pos]) err_q <= 1'b1;
          else begin
            ack_q   <= 1'b1;
            pos_q   <= pos;
            state_q <= S_COMMIT;
          end
        end
        S_COMMIT: state_q <= S_CHECK;
        S_CHECK: if (win || full) begin
          winner_q <= win ? (win_sym ? W_P1 : W_P0) : W_DRAW;
          state_q  <= S_DONE;
        end else begin
          turn_q  <= ~turn_q;
          state_q <= S_WAIT;
        end
        default: ;
      endcase
    end
  end
  assign cell_reset = state_q == S_CLEAR;
  assign cell_set   = state_q == S_COMMIT ? NUM_CELLS'(1) << pos_q : '0;
  assign set_symbol = turn_q;
  assign turn       = turn_q;
  assign move_ack   = ack_q;
  assign move_err   = err_q;
  assign game_over  = state_q == S_DONE;
  assign winner     = winner_q;
endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb_ttt_game_ctrl: scripted and random play against a board-level model
module tb_ttt_game_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       new_game = 1'b0;
  logic       p0_req = 1'b0;
  logic [3:0] p0_pos = '0;
  logic       p1_req = 1'b0;
  logic [3:0] p1_pos = '0;
  logic [8:0] cv = '0;
  logic [8:0] cs = '0;
  logic       cell_reset;
  logic [8:0] cell_set;
  logic       set_symbol;
  logic       turn;
  logic       move_ack;
  logic       move_err;
  logic       game_over;
  logic [1:0] winner;
  int checks = 0;
  int fails = 0;
  ttt_game_ctrl dut (
    .clk(clk), .reset(reset), .new_game(new_game),
    .p0_req(p0_req), .p0_pos(p0_pos), .p1_req(p1_req), .p1_pos(p1_pos),
    .cell_valid(cv), .cell_symbol(cs),
    .cell_reset(cell_reset), .cell_set(cell_set), .set_symbol(set_symbol),
    .turn(turn), .move_ack(move_ack), .move_err(move_err),
    .game_over(game_over), .winner(winner)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (cell_reset) cv <= '0;
    else for (int i = 0; i < 9; i++) if (cell_set[i]) begin
      cv[i] <= 1'b1;
      cs[i] <= set_symbol;
    end
  end
  // model: logical board (-1 empty, else symbol) plus which one-cycle phase is current
  int   lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int   bd [9];
  bit   armed = 0;
  bit   m_clr, m_over, m_ack, m_err, m_chk;
  logic m_turn;
  logic [1:0] m_win;
  int   m_set = -1;
  int   pulse_p = -1;
  task automatic chk(input string n, input logic [8:0] a, input logic [8:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_step();
    logic rq;
    int ps;
    int w;
    bit filled;
    pulse_p = -1;
    if (reset || new_game) begin
      if (reset) armed = 1;
      m_clr = 1; m_turn = 0; m_win = 0; m_over = 0; m_ack = 0; m_err = 0; m_set = -1; m_chk = 0;
      foreach (bd[i]) bd[i] = -1;
      return;
    end
    m_ack = 0;
    m_err = 0;
    if (m_clr) m_clr = 0;
    else if (m_chk) begin
      m_chk = 0;
      w = -1;
      filled = 1;
      foreach (lines[l]) if (bd[lines[l][0]] >= 0 && bd[lines[l][0]] == bd[lines[l][1]] && bd[lines[l][1]] == bd[lines[l][2]]) w = bd[lines[l][0]];
      foreach (bd[i]) if (bd[i] < 0) filled = 0;
      if (w >= 0) begin m_win = w ? 2'b10 : 2'b01; m_over = 1; end
      else if (filled) begin m_win = 2'b11; m_over = 1; end
      else m_turn = ~m_turn;
    end else if (m_set >= 0) begin
      bd[m_set] = m_turn;
      m_set = -1;
      m_chk = 1;
    end else if (!m_over) begin
      rq = m_turn ? p1_req : p0_req;
      ps = m_turn ? int'(p1_pos) : int'(p0_pos);
      if (rq) begin
        pulse_p = m_turn;
        if (ps > 8) m_err = 1;
        else if (bd[ps] >= 0) m_err = 1;
        else begin m_ack = 1; m_set = ps; end
      end
    end
  endtask
  always @(negedge clk) if (armed) begin
    chk("cell_reset", cell_reset, m_clr);
    chk("cell_set", cell_set, m_set >= 0 ? 9'd1 << m_set : 9'd0);
    chk("set_symbol", set_symbol, m_turn);
    chk("turn", turn, m_turn);
    chk("move_ack", move_ack, m_ack);
    chk("move_err", move_err, m_err);
    chk("game_over", game_over, m_over);
    chk("winner", winner, m_win);
  end
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic move(input int p, input logic [3:0] pos);
    bit got = 0;
    if (p == 0) begin p0_req = 1; p0_pos = pos; end
    else begin p1_req = 1; p1_pos = pos; end
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = pulse_p == p;
    end
    if (!got) begin fails++; $display("FAIL move_timeout player=%0d pos=%0d no ack/err", p, pos); end
    p0_req = 0;
    p1_req = 0;
  endtask
  task automatic restart();
    new_game = 1;
    tick();
    new_game = 0;
    tick();
  endtask
  initial begin
    bit got;
    reset = 1;
    tick();
    chk("rst_cell_reset1", cell_reset, 1);
    tick();
    chk("rst_cell_reset2", cell_reset, 1);
    reset = 0;
    tick();
    chk("rst_turn", turn, 0);
    chk("rst_winner", winner, 2'b00);
    chk("rst_game_over", game_over, 0);
    chk("rst_cell_reset_low", cell_reset, 0);
    p1_req = 1; p1_pos = 4;
    idle(3);
    p1_req = 0;
    move(0, 4);
    chk("to_ack", move_ack, 1);
    chk("to_cell_set", cell_set, 9'b000010000);
    chk("to_set_symbol", set_symbol, 0);
    idle(2);
    chk("to_turn1", turn, 1);
    move(1, 4);
    chk("ill_occupied", move_err, 1);
    tick();
    move(1, 9);
    chk("ill_pos9", move_err, 1);
    tick();
    move(1, 15);
    chk("ill_pos15", move_err, 1);
    tick();
    chk("ill_turn", turn, 1);
    restart();
    move(0, 0); move(1, 3); move(0, 1); move(1, 4); move(0, 2);
    idle(2);
    chk("win_winner", winner, 2'b01);
    chk("win_over", game_over, 1);
    p0_req = 1; p0_pos = 5; p1_req = 1; p1_pos = 6;
    idle(4);
    chk("win_held", winner, 2'b01);
    p0_req = 0; p1_req = 0;
    restart();
    move(0, 0); move(1, 1); move(0, 2); move(1, 4); move(0, 3);
    move(1, 5); move(0, 7); move(1, 6);
    idle(2);
    chk("draw_not_early", game_over, 0);
    move(0, 8);
    idle(2);
    chk("draw_winner", winner, 2'b11);
    chk("draw_over", game_over, 1);
    restart();
    p0_req = 1; p0_pos = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin tick(); got = m_ack; end
    if (!got) begin fails++; $display("FAIL rs_timeout no ack"); end
    p0_req = 0;
    new_game = 1;
    tick();
    new_game = 0;
    chk("rs_clear", cell_reset, 1);
    chk("rs_turn", turn, 0);
    chk("rs_no_ack", move_ack, 0);
    tick();
    chk("rs_cells_empty", cv, 9'd0);
    idle(3);
    for (int c = 0; c < 4000; c++) begin
      reset = $urandom % 300 == 0;
      new_game = $urandom % 80 == 0;
      if (p0_req && pulse_p == 0) p0_req = 0;
      else if (!p0_req && $urandom % 3 == 0) begin
        p0_req = 1;
        p0_pos = $urandom % 5 == 0 ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      end
      if (p1_req && pulse_p == 1) p1_req = 0;
      else if (!p1_req && $urandom % 3 == 0) begin
        p1_req = 1;
        p1_pos = $urandom % 5 == 0 ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      end
      tick();
    end
    reset = 0; new_game = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
